// File: rtl/seg_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_ctrl_if
// Description : Bundle for the seg_scan_ctrl display controller: run enable,
//               digit-register write port and the registered display outputs.
// Revision    : 1.0 - initial release
// ============================================================================
interface seg_scan_ctrl_if #(
  parameter int NUM_DIG = 4
);
  localparam int IDX_W = $clog2(NUM_DIG);

  logic               en;
  logic               wr_en;
  logic [IDX_W-1:0]   wr_idx;
  logic [3:0]         wr_data;
  logic               wr_dp;
  logic               a;
  logic               b;
  logic               c;
  logic               d;
  logic               dp_out;
  logic [NUM_DIG-1:0] dig_sel;
  logic               blank;
  logic               frame_tick;

  modport master (
    output en, wr_en, wr_idx, wr_data, wr_dp,
    input  a, b, c, d, dp_out, dig_sel, blank, frame_tick
  );

  modport slave (
    input  en, wr_en, wr_idx, wr_data, wr_dp,
    output a, b, c, d, dp_out, dig_sel, blank, frame_tick
  );
endinterface
`default_nettype wire

// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_ctrl
// Description : Time-multiplexed scan controller for a multi-digit 7-segment
//               display sharing one nibble decoder. Each digit gets a blank
//               GUARD interval followed by a DRIVE interval. All outputs are
//               registered and reflect the state entered at the same edge.
//               Optional macro SEG_LZB_EN enables leading-zero blanking.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_ctrl #(
  parameter int NUM_DIG = 4,
  parameter int PRESC   = 50000,
  parameter int GUARD   = 16
) (
  input  logic           clk,
  input  logic           rst,
  seg_scan_ctrl_if.slave bus
);
  localparam int                 IDX_W        = $clog2(NUM_DIG);
  localparam int                 c_CNT_MAX    = (PRESC > GUARD) ? PRESC : GUARD;
  localparam int                 c_CNT_W      = $clog2(c_CNT_MAX + 1);
  localparam logic [c_CNT_W-1:0] c_PRESC_LAST = c_CNT_W'(PRESC - 1);
  localparam logic [c_CNT_W-1:0] c_GUARD_LAST = c_CNT_W'(GUARD - 1);
  localparam logic [IDX_W-1:0]   c_PTR_LAST   = IDX_W'(NUM_DIG - 1);
  localparam logic [IDX_W:0]     c_NUM_DIG    = (IDX_W + 1)'(NUM_DIG);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GUARD = 2'd1,
    S_DRIVE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [IDX_W-1:0]   r_ptr;
  logic [IDX_W-1:0]   w_ptr_nxt;
  logic [c_CNT_W-1:0] r_cnt;
  logic [c_CNT_W-1:0] w_cnt_nxt;
  logic               w_wrap;
  logic               w_suppress;
  logic               w_lit_nxt;

  logic [3:0]         r_dig [NUM_DIG];
  logic [NUM_DIG-1:0] r_dp;

  logic [3:0]         r_nib;
  logic               r_dp_out;
  logic [NUM_DIG-1:0] r_sel;
  logic               r_blank;
  logic               r_tick;

  // Digit/DP storage: writes accepted in every state, out-of-range index dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_DIG; i++) r_dig[i] <= 4'd0;
      r_dp <= '0;
    end else if (bus.wr_en && ({1'b0, bus.wr_idx} < c_NUM_DIG)) begin
      r_dig[bus.wr_idx] <= bus.wr_data;
      r_dp[bus.wr_idx]  <= bus.wr_dp;
    end
  end

`ifdef SEG_LZB_EN
  logic [NUM_DIG-1:0] w_nz;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIG; gi++) begin : g_nz
      assign w_nz[gi] = (r_dig[gi] != 4'd0) | r_dp[gi];
    end
  endgenerate

  // A digit above 0 goes dark when it and every more significant digit are empty.
  assign w_suppress = (w_ptr_nxt != '0) && ((w_nz >> w_ptr_nxt) == '0);
`else
  assign w_suppress = 1'b0;
`endif

  // Scan sequencing: IDLE -> GUARD -> DRIVE -> GUARD ...; en low forces IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    w_wrap      = 1'b0;
    if (!bus.en) begin
      w_state_nxt = S_IDLE;
      w_ptr_nxt   = '0;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_nxt = S_GUARD;
          w_ptr_nxt   = '0;
          w_cnt_nxt   = '0;
        end
        S_GUARD: begin
          if (r_cnt == c_GUARD_LAST) begin
            w_state_nxt = S_DRIVE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        S_DRIVE: begin
          if (r_cnt == c_PRESC_LAST) begin
            w_state_nxt = S_GUARD;
            w_cnt_nxt   = '0;
            if (r_ptr == c_PTR_LAST) begin
              w_ptr_nxt = '0;
              w_wrap    = 1'b1;
            end else begin
              w_ptr_nxt = r_ptr + 1'b1;
            end
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_ptr_nxt   = '0;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // State, digit pointer and interval counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // A digit is lit only in its DRIVE slot and only when not blanked.
  always_comb w_lit_nxt = (w_state_nxt == S_DRIVE) && !w_suppress;

  // Output registers are loaded from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_nib    <= 4'd0;
      r_dp_out <= 1'b0;
      r_sel    <= '0;
      r_blank  <= 1'b1;
      r_tick   <= 1'b0;
    end else begin
      r_sel    <= w_lit_nxt ? (NUM_DIG'(1) << w_ptr_nxt) : '0;
      r_blank  <= !w_lit_nxt;
      r_nib    <= (w_state_nxt == S_IDLE) ? 4'd0 : r_dig[w_ptr_nxt];
      r_dp_out <= (w_state_nxt == S_IDLE) ? 1'b0 : r_dp[w_ptr_nxt];
      r_tick   <= w_wrap;
    end
  end

  assign bus.a          = r_nib[3];
  assign bus.b          = r_nib[2];
  assign bus.c          = r_nib[1];
  assign bus.d          = r_nib[0];
  assign bus.dp_out     = r_dp_out;
  assign bus.dig_sel    = r_sel;
  assign bus.blank      = r_blank;
  assign bus.frame_tick = r_tick;
endmodule
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_scan_ctrl
// Description : Bench for seg_scan_ctrl. A 4-digit and a 3-digit instance share
//               stimulus; a frame-position model predicts every output cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_scan_ctrl;
  localparam int G = 2;
  localparam int P = 4;

  logic       clk;
  logic       rst;
  logic       en;
  logic       wr_en;
  logic [1:0] wr_idx;
  logic [3:0] wr_data;
  logic       wr_dp;

  int n_tests = 0;
  int n_fail  = 0;

  seg_scan_ctrl_if #(.NUM_DIG(4)) bus4 ();
  seg_scan_ctrl_if #(.NUM_DIG(3)) bus3 ();

  assign bus4.en = en;  assign bus4.wr_en = wr_en;  assign bus4.wr_idx = wr_idx;
  assign bus4.wr_data = wr_data;  assign bus4.wr_dp = wr_dp;
  assign bus3.en = en;  assign bus3.wr_en = wr_en;  assign bus3.wr_idx = wr_idx;
  assign bus3.wr_data = wr_data;  assign bus3.wr_dp = wr_dp;

  seg_scan_ctrl #(.NUM_DIG(4), .PRESC(P), .GUARD(G)) u_dut4 (
    .clk(clk), .rst(rst), .bus(bus4.slave)
  );
  seg_scan_ctrl #(.NUM_DIG(3), .PRESC(P), .GUARD(G)) u_dut3 (
    .clk(clk), .rst(rst), .bus(bus3.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: t counts cycles since the scan (re)started; digit and phase follow
  // directly from t. Expected vector = {sel[3:0], blank, abcd, dp, frame_tick}.
  int         m_t   [2];
  bit         m_run [2];
  logic [3:0] m_reg [2][4];
  logic       m_dpr [2][4];
  logic [10:0] m_exp [2];
  bit         m_valid = 0;

  always @(posedge clk) begin
    int n, dig, ph;
    bit lit, allz, ft;
    logic [3:0] sel;
    for (int k = 0; k < 2; k++) begin
      n = (k == 0) ? 4 : 3;
      if (rst) begin
        for (int j = 0; j < 4; j++) begin m_reg[k][j] = 4'd0; m_dpr[k][j] = 1'b0; end
        m_run[k] = 0; m_t[k] = 0;
        m_exp[k] = {4'b0, 1'b1, 4'b0, 1'b0, 1'b0};
        m_valid = 1;
      end else begin
        if (!en) m_run[k] = 0;
        else if (!m_run[k]) begin m_run[k] = 1; m_t[k] = 0; end
        else m_t[k] = m_t[k] + 1;
        if (!m_run[k]) begin
          m_exp[k] = {4'b0, 1'b1, 4'b0, 1'b0, 1'b0};
        end else begin
          dig = (m_t[k] / (G + P)) % n;
          ph  = m_t[k] % (G + P);
          lit = (ph >= G);
`ifdef SEG_LZB_EN
          if (dig > 0) begin
            allz = 1;
            for (int j = 0; j < n; j++)
              if (j >= dig && (m_reg[k][j] != 0 || m_dpr[k][j])) allz = 0;
            if (allz) lit = 0;
          end
`else
          allz = 0;
`endif
          ft  = (m_t[k] > 0) && (m_t[k] % (n * (G + P)) == 0);
          sel = lit ? 4'(1 << dig) : 4'd0;
          m_exp[k] = {sel, ~lit, m_reg[k][dig], m_dpr[k][dig], ft};
        end
        if (wr_en && int'(wr_idx) < n) begin
          m_reg[k][wr_idx] = wr_data;
          m_dpr[k][wr_idx] = wr_dp;
        end
      end
    end
  end

  // Every cycle after the first reset edge, both DUTs must match the model.
  always @(negedge clk) begin
    if (m_valid) begin
      check("scan4", 16'({bus4.dig_sel, bus4.blank, bus4.a, bus4.b, bus4.c, bus4.d,
                          bus4.dp_out, bus4.frame_tick}), 16'(m_exp[0]));
      check("scan3", 16'({1'b0, bus3.dig_sel, bus3.blank, bus3.a, bus3.b, bus3.c, bus3.d,
                          bus3.dp_out, bus3.frame_tick}), 16'(m_exp[1]));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] idx, input logic [3:0] data, input logic dp);
    wr_en = 1'b1; wr_idx = idx; wr_data = data; wr_dp = dp;
    step();
    wr_en = 1'b0;
  endtask

  function automatic logic [3:0] abcd4();
    return {bus4.a, bus4.b, bus4.c, bus4.d};
  endfunction

  initial begin
    rst = 1'b1; en = 1'b1; wr_en = 1'b0; wr_idx = '0; wr_data = '0; wr_dp = 1'b0;
    repeat (3) step();
    @(negedge clk);
    check("rst_sel",   16'(bus4.dig_sel), 16'h0);
    check("rst_blank", 16'(bus4.blank), 16'h1);
    check("rst_abcd",  16'(abcd4()), 16'h0);
    check("rst_tick",  16'(bus4.frame_tick), 16'h0);

    rst = 1'b0; en = 1'b0;
    wr(2'd0, 4'h5, 1'b0); wr(2'd1, 4'hA, 1'b0); wr(2'd2, 4'h9, 1'b0); wr(2'd3, 4'h1, 1'b0);
    en = 1'b1;
    repeat (3) step(); @(negedge clk);                       // t=2
    check("d0_sel",  16'(bus4.dig_sel), 16'h1);
    check("d0_abcd", 16'(abcd4()), 16'h5);
    check("d0_blank", 16'(bus4.blank), 16'h0);
    repeat (6) step(); @(negedge clk);                       // t=8
    check("d1_sel",  16'(bus4.dig_sel), 16'h2);
    check("d1_abcd", 16'(abcd4()), 16'hA);
    repeat (6) step(); @(negedge clk);                       // t=14
    check("d2_sel",  16'(bus4.dig_sel), 16'h4);
    check("d2_abcd", 16'(abcd4()), 16'h9);
    check("d2_sel3", 16'(bus3.dig_sel), 16'h4);
    repeat (4) step(); @(negedge clk);                       // t=18
    check("tick3",   16'(bus3.frame_tick), 16'h1);
    check("g3_blank", 16'(bus4.blank), 16'h1);
    repeat (2) step(); @(negedge clk);                       // t=20
    check("d3_sel",  16'(bus4.dig_sel), 16'h8);
    check("d3_abcd", 16'(abcd4()), 16'h1);
    repeat (4) step(); @(negedge clk);                       // t=24
    check("tick4",   16'(bus4.frame_tick), 16'h1);
    check("tick4_sel", 16'(bus4.dig_sel), 16'h0);

    repeat (8) step();                                       // t=32, digit 1 drive
    wr(2'd1, 4'h7, 1'b0);                                    // captured at t=33
    step(); @(negedge clk);                                  // t=34
    check("live_sel",  16'(bus4.dig_sel), 16'h2);
    check("live_abcd", 16'(abcd4()), 16'h7);

    en = 1'b0;
    step(); @(negedge clk);
    check("drop_sel",   16'(bus4.dig_sel), 16'h0);
    check("drop_blank", 16'(bus4.blank), 16'h1);
    en = 1'b1;
    repeat (2) step(); @(negedge clk);
    check("restart_guard", 16'(bus4.blank), 16'h1);
    step(); @(negedge clk);
    check("restart_sel", 16'(bus4.dig_sel), 16'h1);

    en = 1'b0;
    wr(2'd0, 4'h0, 1'b0); wr(2'd1, 4'h0, 1'b0); wr(2'd2, 4'h0, 1'b0); wr(2'd3, 4'h0, 1'b0);
    en = 1'b1;
    repeat (3) step(); @(negedge clk);
    check("zero_d0_sel",  16'(bus4.dig_sel), 16'h1);
    check("zero_d0_abcd", 16'(abcd4()), 16'h0);
    repeat (6) step(); @(negedge clk);
`ifdef SEG_LZB_EN
    check("zero_d1_sel", 16'(bus4.dig_sel), 16'h0);
`else
    check("zero_d1_sel", 16'(bus4.dig_sel), 16'h2);
`endif

    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst = ($urandom_range(0, 399) == 0);
      if (en) en = ($urandom_range(0, 79) != 0);
      else    en = ($urandom_range(0, 3) == 0);
      wr_en   = ($urandom_range(0, 5) == 0);
      wr_idx  = 2'($urandom_range(0, 3));
      wr_data = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom);
      wr_dp   = ($urandom_range(0, 7) == 0);
      step();
    end
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
